// File: rtl/lc3b_types.sv
// Shared types for the lc3b memory path: word type, arbiter states and the
// registered memory request bundle.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B} arb_state_t;
  typedef enum logic {PORT_A, PORT_B} arb_port_t;

  typedef struct packed {
    logic       read;
    logic       write;
    logic [1:0] wmask;
    lc3b_word   address;
    lc3b_word   wdata;
  } mem_req_t;

  // read+write together is a write, so the read strobe is suppressed
  function automatic mem_req_t make_req(input logic rd, input logic wr,
                                        input logic [1:0] wm,
                                        input lc3b_word a, input lc3b_word d);
    mem_req_t r;
    r.read    = rd & ~wr;
    r.write   = wr;
    r.wmask   = wm;
    r.address = a;
    r.wdata   = d;
    return r;
  endfunction

endpackage

// File: rtl/mem_req_latch.sv
// Holding register for the granted memory request; drives the mem_* pins.
module mem_req_latch
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  mem_req_t d,
  output mem_req_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (ifetch / data) to single memory port arbiter, one transaction
// outstanding, round-robin or fixed-priority tie break.
module mem_port_arbiter
  import lc3b_types::*;
#(
  parameter bit ROUND_ROBIN  = 1'b1,
  parameter bit FIXED_WINNER = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_a,
  input  logic        write_a,
  input  logic [1:0]  wmask_a,
  input  logic [15:0] address_a,
  input  logic [15:0] wdata_a,
  output logic        resp_a,
  output logic [15:0] rdata_a,
  input  logic        read_b,
  input  logic        write_b,
  input  logic [1:0]  wmask_b,
  input  logic [15:0] address_b,
  input  logic [15:0] wdata_b,
  output logic        resp_b,
  output logic [15:0] rdata_b,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_wmask,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata
);

  arb_state_t state, state_d;
  arb_port_t  last_grant, last_grant_d, win;
  mem_req_t   req_q, req_d;
  logic       req_ld;
  logic       req_a, req_b;

  assign req_a = read_a | write_a;
  assign req_b = read_b | write_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= PORT_A;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    req_ld       = 1'b0;
    req_d        = req_q;
    resp_a       = 1'b0;
    resp_b       = 1'b0;
    win          = PORT_A;
    case (state)
      IDLE: begin
        if (req_a && req_b)
          win = ROUND_ROBIN ? ((last_grant == PORT_A) ? PORT_B : PORT_A)
                            : arb_port_t'(FIXED_WINNER);
        else
          win = req_b ? PORT_B : PORT_A;
        if (req_a || req_b) begin
          req_ld  = 1'b1;
          req_d   = (win == PORT_B)
                    ? make_req(read_b, write_b, wmask_b, address_b, wdata_b)
                    : make_req(read_a, write_a, wmask_a, address_a, wdata_a);
          state_d = (win == PORT_B) ? BUSY_B : BUSY_A;
        end
      end
      BUSY_A, BUSY_B: begin
        // Completion drops the strobes but keeps address/data as last driven
        if (mem_resp) begin
          resp_a       = (state == BUSY_A);
          resp_b       = (state == BUSY_B);
          last_grant_d = (state == BUSY_B) ? PORT_B : PORT_A;
          req_ld       = 1'b1;
          req_d.read   = 1'b0;
          req_d.write  = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  mem_req_latch u_req (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (req_ld),
    .d     (req_d),
    .q     (req_q)
  );

  assign mem_read    = req_q.read;
  assign mem_write   = req_q.write;
  assign mem_wmask   = req_q.wmask;
  assign mem_address = req_q.address;
  assign mem_wdata   = req_q.wdata;

  assign rdata_a = mem_rdata;
  assign rdata_b = mem_rdata;

endmodule
